mul_div_sequencer: RTL and testbench
====================================

# mul_div_sequencer

Multi-cycle multiply/divide sequencer for the VCPU-32 execution stage, next to the ALU and shift-merge unit. It accepts one operation per start pulse and runs a radix-2 shift-add multiply or a restoring divide, one step per clock, on an internal adder and 2×WIDTH shift register. It reports the 2×WIDTH product, or the quotient and remainder, with a single-cycle done pulse.

## Interface
- WIDTH, default `WORD_LENGTH` (32): operand width; must be ≥ 4.
- clk  in  1  single clock; all state changes on the rising edge.
- rstN  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- cancel  in  1  synchronous abort, used on pipeline flush.
- op  in  [0:1]  operation select:
  - 00 MULU
  - 01 MULS
  - 10 DIVU
  - 11 DIVS
- a  in  [0:WIDTH-1]  multiplicand / dividend; captured at start.
- b  in  [0:WIDTH-1]  multiplier / divisor; captured at start.
- busy  out  1  high in SETUP, ITER and FIXUP.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid while done is high:
  - divide by zero;
  - DIVS overflow (MIN / -1);
  - divide op issued when division is not compiled in.
- resHi  out  [0:WIDTH-1]  product high word; remainder for divides.
- resLo  out  [0:WIDTH-1]  product low word; quotient for divides.

## Operation
- States: IDLE, SETUP, ITER, FIXUP, DONE. Encoding is free.
- IDLE, start=1: latch op, a, b → SETUP.
- SETUP:
  - Record signs: sa = a[0], sb = b[0] for signed ops, else 0.
  - Replace each operand with its absolute value.
  - Load the step counter with WIDTH.
  - Divide with b==0 → DONE: err=1, resHi=a, resLo=all-ones.
  - DIVS with a=MIN and b=-1 → DONE: err=1, resHi=0, resLo=MIN.
  - Otherwise → ITER.
- ITER, multiply step: if acc LSB=1, add the multiplicand to the upper half; then shift the {carry, acc} pair right by 1.
- ITER, divide step: shift {rem, quo} left by 1; trial-subtract the divisor from rem; if no borrow, keep the difference and set quo LSB=1.
- ITER: decrement the counter each step; at counter 1 → FIXUP.
- FIXUP, multiply: negate the 2×WIDTH result if sa^sb.
- FIXUP, divide: negate the quotient if sa^sb; negate the remainder if sa. The remainder takes the dividend's sign; quotient truncates toward zero.
- FIXUP: register resHi/resLo; err=0 → DONE.
- DONE: done=1 for one cycle.
  - start=1 → SETUP (back-to-back issue).
  - Else → IDLE.
- start while busy: ignored.
- cancel=1 in any state:
  - Next state IDLE; no done pulse.
  - resHi/resLo/err keep their previous values.
  - cancel has priority over start in the same cycle.
- Unsigned ops: operands are pure magnitudes; no overflow exists; err=0.
- resHi/resLo/err hold their values until the next FIXUP or SETUP-error write.

## Timing
- Reset (rstN=0, immediate): state=IDLE; busy=0, done=0, err=0, resHi=0, resLo=0; counter and operand registers cleared.
- start sampled at edge T0:
  - SETUP during cycle T0..T0+1.
  - ITER for exactly WIDTH cycles.
  - FIXUP for 1 cycle.
  - done high in the cycle following edge T0+WIDTH+2. For WIDTH=32, done appears 34 cycles after start.
- Error early-out: done high in the cycle following edge T0+2.
- Results are valid in the same cycle as done and remain stable afterwards.
- rstN asserted mid-operation: the operation is aborted; outputs go to their reset values asynchronously.
- Throughput: one operation per WIDTH+3 cycles when start is held across DONE.

## Configuration
- Macro `VCPU32_MULDIV_DIV_EN`.
- Defined: DIVU and DIVS are implemented as above.
- Undefined:
  - The divide step, divide fixup and trial-subtract logic are not compiled.
  - op 10/11 goes SETUP → DONE with err=1, resHi=0, resLo=0.
  - MULU/MULS are unchanged.

## Test plan
- Reset check: rstN low, then release → busy=0, done=0, err=0, resHi=resLo=0.
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF → after 34 cycles done=1, resHi=0xFFFFFFFE, resLo=0x00000001, err=0.
- MULS a=-3, b=5 → resHi=0xFFFFFFFF, resLo=0xFFFFFFF1. Then MULS a=0x80000000, b=0x80000000 → resHi=0x40000000, resLo=0.
- DIVS a=-7, b=2 → resLo=0xFFFFFFFD, resHi=0xFFFFFFFF. DIVU a=100, b=7 → resLo=14, resHi=2.
- Divide errors:
  - DIVU b=0, a=5 → done at T0+3 with err=1, resHi=5, resLo=0xFFFFFFFF.
  - DIVS 0x80000000 / 0xFFFFFFFF → err=1, resLo=0x80000000.
- Cancel and reset mid-operation:
  - cancel at ITER step 10 → IDLE, no done, previous results retained.
  - start during busy ignored.
  - start held in DONE → second result after a further 34 cycles.
  - With `VCPU32_MULDIV_DIV_EN` undefined, DIVU → err=1 at T0+3.

Source files
------------

// File: rtl/mul_div_sequencer_if.sv
// -----------------------------------------------------------------------------
// mul_div_sequencer_if
// Request/result bundle between the execution stage and the multiply/divide
// sequencer. The master (execution stage) drives the request side. The slave
// (sequencer) drives status and results.
//
// Signals
//   start, cancel      request pulse / synchronous abort
//   op[0:1]            00 MULU, 01 MULS, 10 DIVU, 11 DIVS (op[0] = divide)
//   a, b [0:WIDTH-1]   operands; bit 0 is the MSB (sign bit)
//   busy, done, err    status; err is meaningful while done is high
//   resHi, resLo       product high/low word, or remainder/quotient
// -----------------------------------------------------------------------------
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

interface mul_div_sequencer_if #(
    parameter int WIDTH = `WORD_LENGTH
);
    logic               start;
    logic               cancel;
    logic [0:1]         op;
    logic [0:WIDTH-1]   a;
    logic [0:WIDTH-1]   b;
    logic               busy;
    logic               done;
    logic               err;
    logic [0:WIDTH-1]   resHi;
    logic [0:WIDTH-1]   resLo;

    modport master (
        output start, cancel, op, a, b,
        input  busy, done, err, resHi, resLo
    );

    modport slave (
        input  start, cancel, op, a, b,
        output busy, done, err, resHi, resLo
    );
endinterface

// File: rtl/mul_div_sequencer.sv
// -----------------------------------------------------------------------------
// mul_div_sequencer
// Multi-cycle multiply/divide unit for the VCPU-32 execution stage. Each
// operation takes one SETUP cycle, then WIDTH ITER steps on a shared 2*WIDTH
// shift register, then one FIXUP cycle. After that, done pulses for one cycle.
// The multiply is radix-2 shift-add on operand magnitudes. The divide is
// restoring division on magnitudes. FIXUP restores the signs.
//
// Ports
//   clk    rising-edge clock
//   rstN   asynchronous active-low reset
//   bus    mul_div_sequencer_if.slave (request in; busy/done/err/results out)
//
// Configuration
//   VCPU32_MULDIV_DIV_EN  defined: DIVU/DIVS are implemented.
//                         undefined: divide ops finish with err=1 and zero
//                         results.
//   WIDTH must match the WIDTH of the connected interface and be >= 4.
// -----------------------------------------------------------------------------
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module mul_div_sequencer #(
    parameter int WIDTH = `WORD_LENGTH
) (
    input  logic                clk,
    input  logic                rstN,
    mul_div_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ITER, S_FIXUP, S_DONE} state_t;

    state_t             r_state;
    logic [1:0]         r_op;       // [1] = divide, [0] = signed
    logic [WIDTH-1:0]   r_a;        // raw operand until SETUP, then magnitude
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;      // {hi, lo}: product, or {rem, quo}
    logic [CW-1:0]      r_cnt;
    logic               r_sa, r_sb;
    logic               r_eflag;    // SETUP found an error; FIXUP publishes r_acc as is
    logic               r_busy, r_done, r_err;
    logic [WIDTH-1:0]   r_res_hi, r_res_lo;

    logic               w_sa, w_sb;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH:0]   w_mul_wide;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_fix;
`ifdef VCPU32_MULDIV_DIV_EN
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_rem_fix, w_quo_fix;
`endif

    always_comb begin
        // NOTE: every always_comb output gets an unconditional value first so no path can infer a latch.
        w_sa       = r_op[0] & r_a[WIDTH-1];
        w_sb       = r_op[0] & r_b[WIDTH-1];
        w_abs_a    = w_sa ? -r_a : r_a;
        w_abs_b    = w_sb ? -r_b : r_b;
        // Multiply step: conditionally add the multiplicand into the upper half.
        // Then shift {carry, acc} right by one.
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
        w_mul_wide = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:0]} : {1'b0, r_acc};
        w_mul_next = w_mul_wide[2*WIDTH:1];
        w_fix      = (r_sa ^ r_sb) ? -r_acc : r_acc;
`ifdef VCPU32_MULDIV_DIV_EN
        // Divide step: shift {rem, quo} left and trial-subtract the divisor.
        // The MSB of the (WIDTH+1)-bit difference is the borrow.
        w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
        w_div_diff  = w_div_shift - {1'b0, r_b};
        w_div_next  = w_div_diff[WIDTH]
                    ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                    : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};
        // The remainder follows the dividend's sign. The quotient truncates toward zero.
        w_rem_fix = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_quo_fix = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        if (r_op[1]) begin
            w_fix = {w_rem_fix, w_quo_fix};
        end
`endif
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            // NOTE: operand and result registers are reset along with the FSM, so the outputs read zero after reset.
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_eflag  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_res_hi <= '0;
            r_res_lo <= '0;
        end else if (bus.cancel) begin
            // Abort from any state. Results and err keep their last values.
            // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_state <= S_SETUP;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_SETUP: begin
                    r_sa    <= w_sa;
                    r_sb    <= w_sb;
                    r_a     <= w_abs_a;
                    r_b     <= w_abs_b;
                    r_cnt   <= CW'(WIDTH);
                    r_eflag <= 1'b0;
                    // Multiply shifts the multiplier through lo. Divide shifts the dividend.
                    r_acc   <= {{WIDTH{1'b0}}, (r_op[1] ? w_abs_a : w_abs_b)};
                    r_state <= S_ITER;
`ifdef VCPU32_MULDIV_DIV_EN
                    // Error cases skip ITER. FIXUP then publishes the preloaded result.
                    if (r_op[1] && r_b == '0) begin
                        r_eflag <= 1'b1;
                        r_acc   <= {r_a, {WIDTH{1'b1}}};
                        r_state <= S_FIXUP;
                    end else if (r_op == 2'b11 && r_a == MIN_VAL && r_b == '1) begin
                        r_eflag <= 1'b1;
                        r_acc   <= {{WIDTH{1'b0}}, MIN_VAL};
                        r_state <= S_FIXUP;
                    end
`else
                    if (r_op[1]) begin
                        r_eflag <= 1'b1;
                        r_acc   <= '0;
                        r_state <= S_FIXUP;
                    end
`endif
                end
                S_ITER: begin
                    r_cnt <= r_cnt - CW'(1);
`ifdef VCPU32_MULDIV_DIV_EN
                    r_acc <= r_op[1] ? w_div_next : w_mul_next;
`else
                    r_acc <= w_mul_next;
`endif
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    r_err                <= r_eflag;
                    {r_res_hi, r_res_lo} <= r_eflag ? r_acc : w_fix;
                    r_state              <= S_DONE;
                    r_busy               <= 1'b0;
                    r_done               <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.err   = r_err;
    assign bus.resHi = r_res_hi;
    assign bus.resLo = r_res_lo;
endmodule

// File: tb/tb_mul_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_div_sequencer
// Self-checking bench for mul_div_sequencer (WIDTH = 32).
// A transaction-level model computes each result with plain integer arithmetic.
// The model also fixes the cycle in which done must appear. A compare process
// checks busy, done, err and the results on every falling clock edge. Directed
// vectors with literal answers pin the model. They are followed by randomized
// traffic: plain issues, cancels, back-to-back issues and ignored starts.
// -----------------------------------------------------------------------------
module tb_mul_div_sequencer;
    localparam int W = 32;

    typedef struct {
        int          t0;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
    } rec_t;

    logic clk;
    logic rstN;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    rec_t        q[$];
    int          kill_at = -1;
    logic [31:0] c_hi = '0;
    logic [31:0] c_lo = '0;
    logic        c_err = 1'b0;

    mul_div_sequencer_if #(.WIDTH(W)) u_if ();

    mul_div_sequencer #(.WIDTH(W)) u_dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour: results from integer arithmetic.
    // Normal ops report done WIDTH+2 edges after start; the error early-out after 2.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic err, output int lat);
        logic [63:0] p;
        int          sa, sb;
        err = 1'b0;
        lat = W + 2;
        hi  = '0;
        lo  = '0;
        sa  = $signed(a);
        sb  = $signed(b);
        case (op)
            2'b00: begin
                p = {32'b0, a} * {32'b0, b};
                {hi, lo} = p;
            end
            2'b01: begin
                p = 64'(longint'(sa) * longint'(sb));
                {hi, lo} = p;
            end
            default: begin
`ifdef VCPU32_MULDIV_DIV_EN
                if (b == 0) begin
                    err = 1'b1; hi = a; lo = '1; lat = 2;
                end else if (op == 2'b11 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    err = 1'b1; hi = '0; lo = 32'h8000_0000; lat = 2;
                end else if (op == 2'b10) begin
                    lo = a / b; hi = a % b;
                end else begin
                    lo = 32'(sa / sb); hi = 32'(sa % sb);
                end
`else
                err = 1'b1; lat = 2;
`endif
            end
        endcase
    endfunction

    // Compare process: every falling edge, DUT status and results versus the model.
    always @(negedge clk) begin
        logic exp_busy, exp_done;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (q.size() > 0 && kill_at >= 0 && cyc >= kill_at) begin
            void'(q.pop_front());
            kill_at = -1;
        end
        if (q.size() > 0) begin
            if (cyc == q[0].t0 + q[0].lat) begin
                exp_done = 1'b1;
                c_hi  = q[0].hi;
                c_lo  = q[0].lo;
                c_err = q[0].err;
                void'(q.pop_front());
            end else if (cyc >= q[0].t0) begin
                exp_busy = 1'b1;
            end
        end
        check("busy",  32'(u_if.busy), 32'(exp_busy));
        check("done",  32'(u_if.done), 32'(exp_done));
        check("err",   32'(u_if.err),  32'(c_err));
        check("resHi", u_if.resHi, c_hi);
        check("resLo", u_if.resLo, c_lo);
    end

    task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        rec_t r;
        model(op, a, b, r.hi, r.lo, r.err, r.lat);
        r.t0 = cyc;
        q.push_back(r);
    endtask

    // Caller guarantees the DUT is idle. Returns #1 after the edge that samples start.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        u_if.op = op; u_if.a = a; u_if.b = b; u_if.start = 1'b1;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        push(op, a, b);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL wait_idle: %0d transactions still pending, expected 0", q.size());
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic run_dir(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                           input logic err, input int lat);
        logic [31:0] mh, ml;
        logic        me;
        int          mlat, t0, n;
        model(op, a, b, mh, ml, me, mlat);
        check({name, "/model_hi"},  mh, hi);
        check({name, "/model_lo"},  ml, lo);
        check({name, "/model_err"}, 32'(me), 32'(err));
        check({name, "/model_lat"}, mlat, lat);
        issue(op, a, b);
        t0 = cyc;
        n  = 0;
        @(negedge clk);
        while (!u_if.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "/latency"}, cyc - t0, lat);
        check({name, "/hi"},  u_if.resHi, hi);
        check({name, "/lo"},  u_if.resLo, lo);
        check({name, "/err"}, 32'(u_if.err), 32'(err));
        @(posedge clk); #1;
        wait_idle();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rstN = 1'b0;
        u_if.start = 1'b0; u_if.cancel = 1'b0; u_if.op = 2'b00; u_if.a = '0; u_if.b = '0;
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        @(posedge clk); #1;
        check("reset/busy",  32'(u_if.busy), 32'd0);
        check("reset/done",  32'(u_if.done), 32'd0);
        check("reset/err",   32'(u_if.err),  32'd0);
        check("reset/resHi", u_if.resHi, 32'd0);
        check("reset/resLo", u_if.resLo, 32'd0);

        run_dir("mulu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
        run_dir("muls_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34);
        run_dir("muls_min2", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 34);
`ifdef VCPU32_MULDIV_DIV_EN
        run_dir("divs_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        run_dir("divu_100d7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
        run_dir("divu_by0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2);
        run_dir("divs_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b1, 2);
        run_dir("divs_by0", 2'b11, 32'h8000_0000, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2);
`else
        run_dir("divu_off", 2'b10, 32'd100, 32'd7, 32'h0, 32'h0, 1'b1, 2);
        run_dir("divs_off", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 1'b1, 2);
`endif
        run_dir("mulu_small", 2'b00, 32'd1234, 32'd5678, 32'h0, 32'd7006652, 1'b0, 34);

        // Cancel at ITER step 10: no done pulse, and the previous results stay.
        issue(2'b00, 32'd3, 32'd3);
        repeat (10) begin @(posedge clk); #1; end
        u_if.cancel = 1'b1;
        kill_at = cyc + 1;
        @(posedge clk); #1;
        u_if.cancel = 1'b0;
        wait_idle();

        // Cancel wins over start in the same idle cycle.
        u_if.op = 2'b01; u_if.a = 32'd9; u_if.b = 32'd9;
        u_if.start = 1'b1; u_if.cancel = 1'b1;
        @(posedge clk); #1;
        u_if.start = 1'b0; u_if.cancel = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // Reset mid-operation: the outputs clear asynchronously.
        issue(2'b01, 32'hFFFF_FFFD, 32'd5);
        repeat (6) begin @(posedge clk); #1; end
        rstN = 1'b0;
        q.delete(); kill_at = -1; c_hi = '0; c_lo = '0; c_err = 1'b0;
        #1;
        check("async_reset/busy",  32'(u_if.busy), 32'd0);
        check("async_reset/resHi", u_if.resHi, 32'd0);
        check("async_reset/resLo", u_if.resLo, 32'd0);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 48; i++) begin
            logic [1:0]  op, op2;
            logic [31:0] a, b, a2, b2;
            int          mode, lat, t0, c;
            op = 2'($urandom_range(0, 3)); a = pick(); b = pick();
            mode = $urandom_range(0, 5);
            if (mode == 1) begin
                // Start stays high through busy (ignored) and is taken in DONE.
                op2 = 2'($urandom_range(0, 3)); a2 = pick(); b2 = pick();
                u_if.op = op; u_if.a = a; u_if.b = b; u_if.start = 1'b1;
                @(posedge clk); #1;
                push(op, a, b);
                t0  = q[q.size()-1].t0;
                lat = q[q.size()-1].lat;
                u_if.op = op2; u_if.a = a2; u_if.b = b2;
                while (cyc < t0 + lat) begin @(posedge clk); #1; end
                @(posedge clk); #1;
                push(op2, a2, b2);
                u_if.start = 1'b0;
            end else begin
                issue(op, a, b);
                lat = q[q.size()-1].lat;
                if (mode == 0) begin
                    // Cancel at a random point, together with a competing start.
                    c = $urandom_range(0, lat - 1);
                    repeat (c) begin @(posedge clk); #1; end
                    u_if.op = 2'($urandom_range(0, 3)); u_if.a = pick(); u_if.b = pick();
                    u_if.cancel = 1'b1; u_if.start = 1'b1;
                    kill_at = cyc + 1;
                    @(posedge clk); #1;
                    u_if.cancel = 1'b0; u_if.start = 1'b0;
                end else if (mode == 2 && lat > 10) begin
                    // A start pulse while busy must be ignored.
                    repeat (5) begin @(posedge clk); #1; end
                    u_if.op = 2'($urandom_range(0, 3)); u_if.a = pick(); u_if.b = pick();
                    u_if.start = 1'b1;
                    @(posedge clk); #1;
                    u_if.start = 1'b0;
                end
            end
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
